// File: rtl/mpi_ahb3_pkg.sv
// Shared constants for the mpi_ahb3 AHB3-Lite initiator.
// Bus encodings, MPI register offsets and FSM state codes.
package mpi_ahb3_pkg;

    localparam logic [1:0]  HTRANS_IDLE    = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ  = 2'b10;
    localparam logic [2:0]  HSIZE_WORD     = 3'b010;
    localparam logic [2:0]  HBURST_SINGLE  = 3'b000;
    localparam logic [3:0]  HPROT_DATA     = 4'b0011;

    localparam logic [31:0] MPI_REG_DATA   = 32'h0;
    localparam logic [31:0] MPI_REG_STATUS = 32'h4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_TX_LEN  = 3'd1;
    localparam state_t ST_TX_FLIT = 3'd2;
    localparam state_t ST_RX_STAT = 3'd3;
    localparam state_t ST_RX_LEN  = 3'd4;
    localparam state_t ST_RX_FLIT = 3'd5;

endpackage

// File: rtl/mpi_ahb3_master_txbuf.sv
// Single-packet outbound flit buffer with fill count.
// pend marks a complete packet (last flit seen or buffer full).
module mpi_ahb3_master_txbuf
    import mpi_ahb3_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int W    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_flit,
    input  logic                       push_last,
    input  logic                       clear,
    input  logic [$clog2(SIZE)-1:0]    rd_idx,
    output logic [W-1:0]               rd_flit,
    output logic [$clog2(SIZE+1)-1:0]  count,
    output logic                       full,
    output logic                       pend
);

    localparam int AW = $clog2(SIZE);
    localparam int CW = $clog2(SIZE + 1);

    logic [W-1:0] mem [SIZE];

    assign full    = (count == CW'(SIZE));
    assign rd_flit = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[count[AW-1:0]] <= push_flit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            pend  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            pend  <= 1'b0;
        end else if (push) begin
            count <= count + CW'(1);
            if (push_last || count == CW'(SIZE - 1)) begin
                pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mpi_ahb3_master.sv
// AHB3-Lite initiator: pushes buffered packets into mpi_ahb3 DATA
// and drains received packets after an interrupt.
module mpi_ahb3_master
    import mpi_ahb3_pkg::*;
#(
    parameter int          NOC_FLIT_WIDTH = 32,
    parameter int          SIZE           = 16,
    parameter logic [31:0] BASE_ADDR      = 32'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NOC_FLIT_WIDTH-1:0] tx_flit,
    input  logic                      tx_last,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic [NOC_FLIT_WIDTH-1:0] rx_flit,
    output logic                      rx_last,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      ahb3_hsel_o,
    output logic [31:0]               ahb3_haddr_o,
    output logic [31:0]               ahb3_hwdata_o,
    output logic                      ahb3_hwrite_o,
    output logic [2:0]                ahb3_hsize_o,
    output logic [2:0]                ahb3_hburst_o,
    output logic [3:0]                ahb3_hprot_o,
    output logic [1:0]                ahb3_htrans_o,
    output logic                      ahb3_hmastlock_o,
    input  logic [31:0]               ahb3_hrdata_i,
    input  logic                      ahb3_hready_i,
    input  logic                      ahb3_hresp_i,
    input  logic                      irq_i,
    output logic                      err_o
);

    localparam int AW = $clog2(SIZE);
    localparam int CW = $clog2(SIZE + 1);

    state_t                    state;
    logic                      dphase;
    logic [31:0]               idx;
    logic [31:0]               rx_len;
    logic [31:0]               end_idx;
    logic [CW-1:0]             tx_count;
    logic [NOC_FLIT_WIDTH-1:0] tx_rd;
    logic                      tx_full;
    logic                      tx_pend;
    logic                      tx_push;
    logic                      tx_clear;
    logic                      is_tx;
    logic                      issue_ok;
    logic                      dphase_ok;
    logic                      dphase_err;
    logic                      last_idx;

    assign is_tx    = (state == ST_TX_LEN) || (state == ST_TX_FLIT);
    assign tx_ready = !rst && !tx_full && !tx_pend && !is_tx;
    assign tx_push  = tx_valid && tx_ready;

    // next RX read only once the output register can take its data
    assign issue_ok = (state != ST_IDLE) && !dphase &&
                      (state != ST_RX_FLIT || !rx_valid || rx_ready);

    assign dphase_err = dphase && ahb3_hresp_i;
    assign dphase_ok  = dphase && ahb3_hready_i && !ahb3_hresp_i;

    assign end_idx  = (state == ST_TX_FLIT) ? 32'(tx_count) : rx_len;
    assign last_idx = (idx == end_idx - 32'd1);

    assign tx_clear = (dphase_err && is_tx) ||
                      (dphase_ok && state == ST_TX_FLIT && last_idx);

    mpi_ahb3_master_txbuf #(
        .SIZE (SIZE),
        .W    (NOC_FLIT_WIDTH)
    ) u_txbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_flit (tx_flit),
        .push_last (tx_last),
        .clear     (tx_clear),
        .rd_idx    (idx[AW-1:0]),
        .rd_flit   (tx_rd),
        .count     (tx_count),
        .full      (tx_full),
        .pend      (tx_pend)
    );

    assign ahb3_hsel_o      = (state != ST_IDLE);
    assign ahb3_haddr_o     = (state == ST_IDLE) ? 32'h0 :
                              BASE_ADDR + ((state == ST_RX_STAT) ?
                              MPI_REG_STATUS : MPI_REG_DATA);
    assign ahb3_htrans_o    = issue_ok ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahb3_hwrite_o    = is_tx;
    assign ahb3_hwdata_o    = !(dphase && is_tx) ? 32'h0 :
                              (state == ST_TX_LEN) ? 32'(tx_count) : tx_rd;
    assign ahb3_hsize_o     = HSIZE_WORD;
    assign ahb3_hburst_o    = HBURST_SINGLE;
    assign ahb3_hprot_o     = HPROT_DATA;
    assign ahb3_hmastlock_o = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            dphase   <= 1'b0;
            idx      <= 32'h0;
            rx_len   <= 32'h0;
            rx_flit  <= '0;
            rx_valid <= 1'b0;
            rx_last  <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            err_o <= dphase_err;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
                rx_last  <= 1'b0;
            end
            if (issue_ok && ahb3_hready_i) begin
                dphase <= 1'b1;
            end
            if (dphase_err) begin
                state    <= ST_IDLE;
                dphase   <= 1'b0;
                rx_valid <= 1'b0;
                rx_last  <= 1'b0;
            end else if (dphase_ok) begin
                dphase <= 1'b0;
                unique case (state)
                    ST_TX_LEN: begin
                        state <= ST_TX_FLIT;
                        idx   <= 32'h0;
                    end
                    ST_TX_FLIT: begin
                        if (last_idx) state <= ST_IDLE;
                        else          idx   <= idx + 32'd1;
                    end
                    ST_RX_STAT: begin
                        state <= ahb3_hrdata_i[0] ? ST_RX_LEN : ST_IDLE;
                    end
                    ST_RX_LEN: begin
                        rx_len <= ahb3_hrdata_i;
                        idx    <= 32'h0;
                        state  <= (ahb3_hrdata_i == 32'h0) ? ST_IDLE : ST_RX_FLIT;
                    end
                    ST_RX_FLIT: begin
                        rx_flit  <= ahb3_hrdata_i;
                        rx_valid <= 1'b1;
                        rx_last  <= last_idx;
                        if (last_idx) state <= ST_IDLE;
                        else          idx   <= idx + 32'd1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state == ST_IDLE) begin
                if (tx_pend)    state <= ST_TX_LEN;
                else if (irq_i) state <= ST_RX_STAT;
            end
        end
    end

endmodule

// File: tb/tb_mpi_ahb3_master.sv
// Directed bench for mpi_ahb3_master with a small AHB slave model
// standing in for mpi_ahb3 (DATA/STATUS registers, stalls, errors).
module tb_mpi_ahb3_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tx_flit;
    logic        tx_last, tx_valid, tx_ready;
    logic [31:0] rx_flit;
    logic        rx_last, rx_valid, rx_ready;
    logic        hsel, hwrite, hmastlock, hready, hresp, irq, err;
    logic [31:0] haddr, hwdata, hrdata;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mpi_ahb3_master #(
        .NOC_FLIT_WIDTH (32),
        .SIZE           (16),
        .BASE_ADDR      (32'h0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tx_flit          (tx_flit),
        .tx_last          (tx_last),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .rx_flit          (rx_flit),
        .rx_last          (rx_last),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .ahb3_hsel_o      (hsel),
        .ahb3_haddr_o     (haddr),
        .ahb3_hwdata_o    (hwdata),
        .ahb3_hwrite_o    (hwrite),
        .ahb3_hsize_o     (hsize),
        .ahb3_hburst_o    (hburst),
        .ahb3_hprot_o     (hprot),
        .ahb3_htrans_o    (htrans),
        .ahb3_hmastlock_o (hmastlock),
        .ahb3_hrdata_i    (hrdata),
        .ahb3_hready_i    (hready),
        .ahb3_hresp_i     (hresp),
        .irq_i            (irq),
        .err_o            (err)
    );

    // slave model state
    logic        s_pend = 1'b0;
    logic        s_wr = 1'b0;
    logic [31:0] s_addr = 32'h0;
    int          s_stall = 0;
    logic [31:0] rxmem [32];
    int          rxn = 0, rxp = 0;
    int          stall_cfg = 0, err_wr = -1, wr_cnt = 0;
    int          nonseq_cnt = 0, overlap_cnt = 0, unstable_cnt = 0, err_cnt = 0;
    logic        held = 1'b0;
    logic [31:0] prev_hw = 32'h0, prev_ha = 32'h0;
    logic [31:0] wq_d [$];
    logic [31:0] lq_a [$];
    logic        lq_w [$];
    logic [31:0] rxq [$];
    logic        rxl [$];

    assign hready = !(s_pend && s_stall > 0);
    assign hresp  = s_pend && s_wr && (wr_cnt == err_wr);
    assign hrdata = (s_pend && !s_wr) ?
                    ((s_addr == 32'h4) ? {31'b0, rxp < rxn} : rxmem[rxp[4:0]]) :
                    32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_pend  <= 1'b0;
            s_stall <= 0;
            held    <= 1'b0;
        end else begin
            if (htrans == 2'b10 && s_pend) overlap_cnt <= overlap_cnt + 1;
            if (err) err_cnt <= err_cnt + 1;
            if (held && (hwdata != prev_hw || haddr != prev_ha))
                unstable_cnt <= unstable_cnt + 1;
            held    <= s_pend && !hready;
            prev_hw <= hwdata;
            prev_ha <= haddr;
            if (rx_valid && rx_ready) begin
                rxq.push_back(rx_flit);
                rxl.push_back(rx_last);
            end
            if (s_pend && hready) begin
                s_pend <= 1'b0;
                if (s_wr) begin
                    wq_d.push_back(hwdata);
                    wr_cnt <= wr_cnt + 1;
                end else if (s_addr == 32'h0) begin
                    rxp <= rxp + 1;
                end
            end else if (s_pend) begin
                s_stall <= s_stall - 1;
            end
            if (htrans == 2'b10 && hready) begin
                s_pend     <= 1'b1;
                s_addr     <= haddr;
                s_wr       <= hwrite;
                s_stall    <= stall_cfg;
                nonseq_cnt <= nonseq_cnt + 1;
                lq_a.push_back(haddr);
                lq_w.push_back(hwrite);
            end
        end
    end

    function automatic logic [31:0] wget(int i);
        if (i < wq_d.size()) return wq_d[i];
        return 32'hx;
    endfunction

    function automatic logic [31:0] aget(int i);
        if (i < lq_a.size()) return lq_a[i];
        return 32'hx;
    endfunction

    function automatic logic wrget(int i);
        if (i < lq_w.size()) return lq_w[i];
        return 1'bx;
    endfunction

    function automatic logic [31:0] rget(int i);
        if (i < rxq.size()) return rxq[i];
        return 32'hx;
    endfunction

    function automatic logic lget(int i);
        if (i < rxl.size()) return rxl[i];
        return 1'bx;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(logic [31:0] f, logic l);
        int n = 0;
        tx_flit  = f;
        tx_last  = l;
        tx_valid = 1'b1;
        while (!tx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(n < 300), 32'd1);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic wait_wq(int n);
        for (int i = 0; i < 300 && wq_d.size() < n; i++) @(negedge clk);
    endtask

    task automatic wait_rxq(int n);
        for (int i = 0; i < 300 && rxq.size() < n; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, nb, lb, rb, eb, n;
        rst = 1'b1; tx_flit = 32'h0; tx_last = 1'b0; tx_valid = 1'b0;
        rx_ready = 1'b1; irq = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_htrans", 32'(htrans), 32'h0);
        check("rst_hsel", 32'(hsel), 32'h0);
        check("rst_haddr", haddr, 32'h0);
        check("rst_hwdata", hwdata, 32'h0);
        check("rst_hwrite", 32'(hwrite), 32'h0);
        check("rst_hsize", 32'(hsize), 32'h2);
        check("rst_hburst", 32'(hburst), 32'h0);
        check("rst_hprot", 32'(hprot), 32'h3);
        check("rst_hmastlock", 32'(hmastlock), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_tx_ready", 32'(tx_ready), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tx_ready", 32'(tx_ready), 32'h1);

        // 3-flit outbound packet
        send(32'hAA, 1'b0);
        send(32'hBB, 1'b0);
        send(32'hCC, 1'b1);
        wait_wq(4);
        check("tx_nwr", 32'(wq_d.size()), 32'd4);
        check("tx_len", wget(0), 32'd3);
        check("tx_f0", wget(1), 32'hAA);
        check("tx_f1", wget(2), 32'hBB);
        check("tx_f2", wget(3), 32'hCC);
        check("tx_addr", aget(3), 32'h0);
        check("tx_hwrite", 32'(wrget(0)), 32'h1);
        repeat (2) @(negedge clk);
        check("tx_nonseq", 32'(nonseq_cnt), 32'd4);
        check("tx_err", 32'(err_cnt), 32'd0);
        check("tx_ready_after", 32'(tx_ready), 32'h1);
        check("tx_hsel_after", 32'(hsel), 32'h0);

        // slave stalls each data phase for 2 cycles
        stall_cfg = 2;
        wb = wq_d.size();
        nb = nonseq_cnt;
        send(32'h12, 1'b0);
        send(32'h34, 1'b1);
        wait_wq(wb + 3);
        stall_cfg = 0;
        repeat (2) @(negedge clk);
        check("st_len", wget(wb), 32'd2);
        check("st_f0", wget(wb + 1), 32'h12);
        check("st_f1", wget(wb + 2), 32'h34);
        check("st_nonseq", 32'(nonseq_cnt - nb), 32'd3);
        check("st_unstable", 32'(unstable_cnt), 32'd0);
        check("st_overlap", 32'(overlap_cnt), 32'd0);

        // inbound packet of 2 flits
        rxmem[0] = 32'd2; rxmem[1] = 32'h11; rxmem[2] = 32'h22;
        rxn = 3;
        rb = rxq.size();
        lb = lq_a.size();
        irq = 1'b1;
        wait_rxq(rb + 2);
        irq = 1'b0;
        repeat (6) @(negedge clk);
        check("rx_n", 32'(rxq.size() - rb), 32'd2);
        check("rx_f0", rget(rb), 32'h11);
        check("rx_l0", 32'(lget(rb)), 32'h0);
        check("rx_f1", rget(rb + 1), 32'h22);
        check("rx_l1", 32'(lget(rb + 1)), 32'h1);
        check("rx_first_stat", aget(lb), 32'h4);
        check("rx_first_rd", 32'(wrget(lb)), 32'h0);

        // pending TX wins against a simultaneous irq
        rxmem[3] = 32'd1; rxmem[4] = 32'h77;
        rxn = 5;
        lb = lq_a.size();
        wb = wq_d.size();
        rb = rxq.size();
        send(32'h99, 1'b1);
        irq = 1'b1;
        wait_rxq(rb + 1);
        irq = 1'b0;
        repeat (6) @(negedge clk);
        check("arb_w0", 32'(wrget(lb)), 32'h1);
        check("arb_w1", 32'(wrget(lb + 1)), 32'h1);
        check("arb_stat_addr", aget(lb + 2), 32'h4);
        check("arb_stat_rd", 32'(wrget(lb + 2)), 32'h0);
        check("arb_len", wget(wb), 32'd1);
        check("arb_f0", wget(wb + 1), 32'h99);
        check("arb_rx", rget(rb), 32'h77);
        check("arb_rx_last", 32'(lget(rb)), 32'h1);

        // sink back-pressure mid-packet
        rxmem[5] = 32'd3; rxmem[6] = 32'h33; rxmem[7] = 32'h44; rxmem[8] = 32'h55;
        rxn = 9;
        rb = rxq.size();
        rx_ready = 1'b0;
        irq = 1'b1;
        n = 0;
        while (!rx_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        irq = 1'b0;
        check("bp_valid", 32'(rx_valid), 32'h1);
        nb = nonseq_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rx_valid), 32'h1);
            check("bp_hold_flit", rx_flit, 32'h33);
        end
        check("bp_no_read", 32'(nonseq_cnt - nb), 32'd0);
        rx_ready = 1'b1;
        wait_rxq(rb + 3);
        repeat (6) @(negedge clk);
        check("bp_f0", rget(rb), 32'h33);
        check("bp_f1", rget(rb + 1), 32'h44);
        check("bp_f2", rget(rb + 2), 32'h55);
        check("bp_l1", 32'(lget(rb + 1)), 32'h0);
        check("bp_l2", 32'(lget(rb + 2)), 32'h1);

        // ERROR response on the 2nd flit write
        wb = wq_d.size();
        eb = err_cnt;
        err_wr = wr_cnt + 2;
        send(32'hA1, 1'b0);
        send(32'hA2, 1'b0);
        send(32'hA3, 1'b1);
        for (int i = 0; i < 300 && err_cnt == eb; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        err_wr = -1;
        check("er_pulse", 32'(err_cnt - eb), 32'd1);
        check("er_hsel", 32'(hsel), 32'h0);
        check("er_htrans", 32'(htrans), 32'h0);
        check("er_tx_ready", 32'(tx_ready), 32'h1);
        check("er_nwr", 32'(wq_d.size() - wb), 32'd3);
        check("er_len", wget(wb), 32'd3);
        send(32'h5A, 1'b1);
        wait_wq(wb + 5);
        check("er_next_len", wget(wb + 3), 32'd1);
        check("er_next_f0", wget(wb + 4), 32'h5A);

        // async reset during a stalled transfer
        stall_cfg = 6;
        send(32'h66, 1'b1);
        n = 0;
        while (!s_pend && n < 300) begin
            @(negedge clk);
            n++;
        end
        wb = wq_d.size();
        #2 rst = 1'b1;
        #1;
        check("ar_htrans", 32'(htrans), 32'h0);
        check("ar_hsel", 32'(hsel), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        stall_cfg = 0;
        repeat (10) @(negedge clk);
        check("ar_no_write", 32'(wq_d.size() - wb), 32'd0);
        check("ar_tx_ready", 32'(tx_ready), 32'h1);
        check("ar_idle", 32'(hsel), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
